// File: rtl/alu_seq.sv
// Sequencer around an external combinational ALU.
// Holds operands stable for SETTLE cycles, then captures the result.
module alu_seq #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_A,
  input  logic [N-1:0] req_B,
  input  logic [2:0]   req_Cntr,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [2:0]   alu_Cntr,
  input  logic [N-1:0] alu_Result,
  input  logic [3:0]   alu_Flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_Result,
  output logic [3:0]   rsp_Flags,
  output logic [3:0]   sticky_Flags,
  input  logic         clr_sticky,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         vld_q, vld_d;
  logic [N-1:0] res_q, res_d;
  logic [3:0]   flg_q, flg_d;
  logic [3:0]   stk_q, stk_d;
  logic [15:0]  cnt_ops_q, cnt_ops_d;
  logic         capture;

  assign req_ready    = (state_q == IDLE);
  assign alu_A        = a_q;
  assign alu_B        = b_q;
  assign alu_Cntr     = op_q;
  assign rsp_valid    = vld_q;
  assign rsp_Result   = res_q;
  assign rsp_Flags    = flg_q;
  assign sticky_Flags = stk_q;
  assign op_count     = cnt_ops_q;

  // Next-state, settle countdown, capture and flag accumulation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    vld_d     = vld_q;
    res_d     = res_q;
    flg_d     = flg_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_A;
          b_d     = req_B;
          op_d    = req_Cntr;
          cnt_d   = CNT_INIT;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          res_d   = alu_Result;
          flg_d   = alu_Flags;
          vld_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear acts first, so a same-edge capture still lands.
    stk_d = clr_sticky ? 4'd0 : stk_q;
    if (capture) begin
      stk_d = stk_d | alu_Flags;
    end
    cnt_ops_d = cnt_ops_q;
    if (capture && cnt_ops_q != 16'hFFFF) begin
      cnt_ops_d = cnt_ops_q + 16'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 3'd0;
      vld_q     <= 1'b0;
      res_q     <= '0;
      flg_q     <= 4'd0;
      stk_q     <= 4'd0;
      cnt_ops_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      vld_q     <= vld_d;
      res_q     <= res_d;
      flg_q     <= flg_d;
      stk_q     <= stk_d;
      cnt_ops_q <= cnt_ops_d;
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Parameters
REQ-001 The block SHALL have parameter N, default 8, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter SETTLE, default 2, meaning the ALU settle time in clock cycles; the legal range is 1..15.

Interface
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  operation request valid.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_A  in  N  operand A.
REQ-008 req_B  in  N  operand B.
REQ-009 req_Cntr  in  3  ALU operation select.
REQ-010 alu_A, alu_B  out  N each  operands driven to the external combinational ALU.
REQ-011 alu_Cntr  out  3  operation select driven to the ALU.
REQ-012 alu_Result  in  N  ALU result.
REQ-013 alu_Flags  in  4  ALU flags; bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-014 rsp_valid  out  1  response valid.
REQ-015 rsp_ready  in  1  consumer accepts the response.
REQ-016 rsp_Result  out  N  captured result.
REQ-017 rsp_Flags  out  4  captured flags.
REQ-018 sticky_Flags  out  4  OR of all captured flags since reset or the last clear.
REQ-019 clr_sticky  in  1  single-cycle clear of sticky_Flags.
REQ-020 op_count  out  16  count of completed captures, saturating.

Function
REQ-021 The FSM SHALL have three states, IDLE, DRIVE and RESP, with req_ready = (state==IDLE) decoded combinationally.
REQ-022 In IDLE, on an edge with req_valid=1, the block SHALL register req_A/req_B/req_Cntr into alu_A/alu_B/alu_Cntr, load settle counter cnt=SETTLE-1, and go to DRIVE.
REQ-023 In IDLE with req_valid=0, the block SHALL hold all registers.
REQ-024 In DRIVE, alu_A/alu_B/alu_Cntr SHALL be held stable, and req_A/req_B/req_Cntr changes SHALL have no effect.
REQ-025 In DRIVE with cnt!=0, each edge SHALL decrement cnt.
REQ-026 In DRIVE with cnt==0, the edge SHALL capture alu_Result into rsp_Result and alu_Flags into rsp_Flags, set rsp_valid=1, and go to RESP.
REQ-027 Latency: rsp_valid SHALL rise exactly SETTLE edges after the request-accept edge (SETTLE=2 gives 2 cycles).
REQ-028 In RESP, rsp_valid, rsp_Result and rsp_Flags SHALL stay stable until an edge with rsp_ready=1.
REQ-029 At an RESP edge with rsp_ready=1, the block SHALL clear rsp_valid and go to IDLE; a new request is accepted no earlier than the following edge.
REQ-030 Minimum issue interval SHALL be SETTLE+2 cycles when rsp_ready is tied high.
REQ-031 On the capture edge, the block SHALL update sticky_Flags <= sticky_Flags | alu_Flags.
REQ-032 With clr_sticky=1 on a non-capture edge, the block SHALL set sticky_Flags <= 0.
REQ-033 With clr_sticky=1 on the capture edge, the block SHALL set sticky_Flags <= alu_Flags (the clear applies first, the capture wins).
REQ-034 On each capture edge, the block SHALL increment op_count by 1, saturating at 16'hFFFF (no wrap).
REQ-035 alu_Result and alu_Flags SHALL be sampled only on the capture edge; values in other cycles SHALL be ignored.

Reset
REQ-036 On rst_n=0, at any time and in any state, the block SHALL go to IDLE immediately and force: alu_A=0, alu_B=0, alu_Cntr=0, cnt=0, rsp_valid=0, rsp_Result=0, rsp_Flags=0, sticky_Flags=0, op_count=0.
REQ-037 Reset during DRIVE or RESP SHALL abandon the operation: no capture occurs and op_count is not incremented.
REQ-038 After rst_n deasserts, req_ready SHALL be 1 on the first rising edge.

Verification
REQ-039 Single op: SETTLE=2, req A=15 B=10 Cntr=000, ALU stub returns Result=25 Flags=0000 -> rsp_valid rises 2 edges after accept with rsp_Result=25, rsp_Flags=0000, op_count=1.
REQ-040 Backpressure: rsp_ready held 0 for 5 cycles, with req_A changed to 255 during RESP -> rsp_Result and rsp_Flags stable, req_ready=0 throughout; release -> IDLE the next cycle.
REQ-041 Sticky: two ops with stub flags 1000 then 0010 -> sticky_Flags=1010; clr_sticky pulse -> 0000; clr_sticky on a capture edge with flags 0101 -> 0101.
REQ-042 Reset mid-DRIVE: assert rst_n=0 one cycle after accept -> all outputs 0 asynchronously, op_count remains 0, req_ready=1 after release.
REQ-043 Saturation: preload or run op_count to 16'hFFFF, then one more op -> op_count stays 16'hFFFF.
REQ-044 Settle stability: stub changes alu_Result every cycle during DRIVE -> rsp_Result equals the value present at the capture edge only; alu_A/alu_B/alu_Cntr unchanged during DRIVE.
